hazard_ctrl_pipe: RTL and testbench



---
 rtl/hazard_ctrl_pipe.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_pipe.sv
// Hazard unit for the MIPS pipeline: tracks in-flight writers after D and
// produces the D-stage stall, rs/rt forwarding selects and the HI/LO busy stall.
module hazard_ctrl_pipe #(
    parameter int NSTAGE  = 3,
    parameter int TW      = 2,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_a1,
    input  logic [4:0]    d_a2,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_we,
    input  logic [4:0]    d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic [2:0]    fwd_rs_sel,
    output logic [2:0]    fwd_rt_sel,
    output logic          md_busy
);

    localparam logic [TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic          hit;
        logic [2:0]    sel;
        logic [TW-1:0] tnew;
    } match_t;

    logic [NSTAGE-1:0]           we_q, we_d;
    logic [NSTAGE-1:0][4:0]      a3_q, a3_d;
    logic [NSTAGE-1:0][TW-1:0]   tnew_q, tnew_d;
    logic [CW-1:0]               md_cnt_q, md_cnt_d;
    match_t                      rs_m, rt_m;
    logic                        gpr_stall;
    logic                        md_stall;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    // Scan from the farthest stage inward so the nearest producer overwrites.
    // A zero index never matches, which also makes a3=0 entries inert.
    function automatic match_t find_producer(
        input logic [4:0]                idx,
        input logic [TW-1:0]             tuse,
        input logic [NSTAGE-1:0]         we,
        input logic [NSTAGE-1:0][4:0]    a3,
        input logic [NSTAGE-1:0][TW-1:0] tnew
    );
        match_t m;
        m = '0;
        if (idx != 5'd0 && tuse != TUSE_NONE) begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (we[k] && a3[k] == idx) begin
                    m.hit  = 1'b1;
                    m.sel  = 3'(k + 1);
                    m.tnew = tnew[k];
                end
            end
        end
        return m;
    endfunction

    assign md_busy = (md_cnt_q != '0);

    always_comb begin
        rs_m       = find_producer(d_a1, d_tuse_rs, we_q, a3_q, tnew_q);
        rt_m       = find_producer(d_a2, d_tuse_rt, we_q, a3_q, tnew_q);
        gpr_stall  = (rs_m.hit && (rs_m.tnew > d_tuse_rs)) ||
                     (rt_m.hit && (rt_m.tnew > d_tuse_rt));
        md_stall   = d_md_use && md_busy;
        stall      = gpr_stall || md_stall;
        fwd_rs_sel = (rs_m.hit && rs_m.tnew == '0) ? rs_m.sel : 3'd0;
        fwd_rt_sel = (rt_m.hit && rt_m.tnew == '0) ? rt_m.sel : 3'd0;
    end

    // Stage 1 takes a bubble on stall; older stages keep draining regardless.
    always_comb begin
        we_d   = '0;
        a3_d   = '0;
        tnew_d = '0;
        if (!stall) begin
            we_d[0]   = d_we;
            a3_d[0]   = d_a3;
            tnew_d[0] = d_tnew;
        end
        for (int k = 1; k < NSTAGE; k++) begin
            we_d[k]   = we_q[k-1];
            a3_d[k]   = a3_q[k-1];
            tnew_d[k] = sat_dec(tnew_q[k-1]);
        end

        if (d_md_start && !stall) begin
            md_cnt_d = d_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= '0;
            a3_q     <= '0;
            tnew_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            we_q     <= we_d;
            a3_q     <= a3_d;
            tnew_q   <= tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench for hazard_ctrl_pipe: a behavioural model predicts each
// cycle's outputs; a second NSTAGE=5 instance gets directed checks.
module tb_hazard_ctrl_pipe;

    logic       clk;
    logic       reset;
    logic [4:0] d_a1, d_a2, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_we, d_md_start, d_md_div, d_md_use;
    logic       stall, md_busy;
    logic [2:0] fwd_rs_sel, fwd_rt_sel;

    logic [4:0] n5_a1, n5_a2, n5_a3;
    logic [2:0] n5_tuse_rs, n5_tuse_rt, n5_tnew;
    logic       n5_we;
    logic       n5_stall, n5_md_busy;
    logic [2:0] n5_rs_sel, n5_rt_sel;

    hazard_ctrl_pipe u_dut (
        .clk(clk), .reset(reset),
        .d_a1(d_a1), .d_a2(d_a2), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_we(d_we), .d_a3(d_a3), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy)
    );

    hazard_ctrl_pipe #(.NSTAGE(5), .TW(3)) u_dut5 (
        .clk(clk), .reset(reset),
        .d_a1(n5_a1), .d_a2(n5_a2), .d_tuse_rs(n5_tuse_rs), .d_tuse_rt(n5_tuse_rt),
        .d_we(n5_we), .d_a3(n5_a3), .d_tnew(n5_tnew),
        .d_md_start(1'b0), .d_md_div(1'b0), .d_md_use(1'b0),
        .stall(n5_stall), .fwd_rs_sel(n5_rs_sel), .fwd_rt_sel(n5_rt_sel),
        .md_busy(n5_md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference model state: stage index 0 is E.
    bit m_we   [3];
    int m_a3   [3];
    int m_tnew [3];
    int m_cnt;

    typedef struct {
        string tag;
        int    stl;
        int    rs;
        int    rt;
        int    busy;
    } sb_t;
    sb_t sb_q[$];

    int obs_stall, obs_rs, obs_rt, obs_busy;

    task automatic model_match(input int idx, input int tuse, output int sel, output bit stl);
        sel = 0;
        stl = 0;
        if (idx != 0 && tuse != 3) begin
            for (int k = 0; k < 3; k++) begin
                if (m_we[k] && m_a3[k] == idx) begin
                    if (m_tnew[k] > tuse) stl = 1;
                    if (m_tnew[k] == 0) sel = k + 1;
                    break;
                end
            end
        end
    endtask

    task automatic model_tick(input bit stl);
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_we[k] = 0; m_a3[k] = 0; m_tnew[k] = 0;
            end
            m_cnt = 0;
        end else begin
            for (int k = 2; k >= 1; k--) begin
                m_we[k]   = m_we[k-1];
                m_a3[k]   = m_a3[k-1];
                m_tnew[k] = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
            end
            m_we[0]   = stl ? 1'b0 : (d_we && d_a3 != 0);
            m_a3[0]   = stl ? 0 : int'(d_a3);
            m_tnew[0] = stl ? 0 : int'(d_tnew);
            if (d_md_start && !stl) m_cnt = d_md_div ? 10 : 5;
            else if (m_cnt > 0) m_cnt--;
        end
    endtask

    task automatic drive(input int a1, input int a2, input int trs, input int trt,
                         input int we, input int a3, input int tnew,
                         input int mds, input int mdd, input int mdu);
        d_a1 = 5'(a1); d_a2 = 5'(a2);
        d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt);
        d_we = 1'(we); d_a3 = 5'(a3); d_tnew = 2'(tnew);
        d_md_start = 1'(mds); d_md_div = 1'(mdd); d_md_use = 1'(mdu);
    endtask

    task automatic nop();
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step(input string tag);
        sb_t e, got;
        int  sr, st;
        bit  s1, s2;
        model_match(int'(d_a1), int'(d_tuse_rs), sr, s1);
        model_match(int'(d_a2), int'(d_tuse_rt), st, s2);
        e.tag  = tag;
        e.stl  = (s1 || s2 || (d_md_use && m_cnt != 0)) ? 1 : 0;
        e.rs   = sr;
        e.rt   = st;
        e.busy = (m_cnt != 0) ? 1 : 0;
        sb_q.push_back(e);
        @(negedge clk);
        obs_stall = int'(stall);
        obs_rs    = int'(fwd_rs_sel);
        obs_rt    = int'(fwd_rt_sel);
        obs_busy  = int'(md_busy);
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb_q.pop_front();
            chk({got.tag, ".stall"}, obs_stall, got.stl);
            chk({got.tag, ".rs"},    obs_rs,    got.rs);
            chk({got.tag, ".rt"},    obs_rt,    got.rt);
            chk({got.tag, ".busy"},  obs_busy,  got.busy);
        end
        @(posedge clk);
        model_tick(e.stl != 0);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) step("flush");
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            m_we[k] = 0; m_a3[k] = 0; m_tnew[k] = 0;
        end
        m_cnt = 0;
        reset = 1'b1;
        nop();
        n5_a1 = 0; n5_a2 = 0; n5_tuse_rs = 7; n5_tuse_rt = 7;
        n5_we = 0; n5_a3 = 0; n5_tnew = 0;
        repeat (2) @(posedge clk);
        #1;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst.stall", int'(stall), 0);
        chk("rst.rs", int'(fwd_rs_sel), 0);
        chk("rst.rt", int'(fwd_rt_sel), 0);
        chk("rst.busy", int'(md_busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        nop();
        step("idle");

        // lw $1 then add $2,$1,$3
        drive(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
        step("lw");
        drive(1, 3, 1, 1, 1, 2, 1, 0, 0, 0);
        step("add0");
        chk("c1.stall_first", obs_stall, 1);
        step("add1");
        chk("c1.stall_second", obs_stall, 0);
        drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        step("rd1_w");
        chk("c1.fwd_w", obs_rs, 3);
        flush();

        // ori $1 then beq $1,$0
        drive(0, 0, 3, 3, 1, 1, 1, 0, 0, 0);
        step("ori");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("beq0");
        chk("c2.stall", obs_stall, 1);
        step("beq1");
        chk("c2.stall_end", obs_stall, 0);
        chk("c2.fwd_m", obs_rs, 2);
        flush();

        // two writers of $5, nearest wins; $0 never matches
        drive(0, 0, 3, 3, 1, 5, 0, 0, 0, 0);
        step("w5a");
        step("w5b");
        drive(5, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        step("rd5");
        chk("c3.near_rs", obs_rs, 1);
        chk("c3.near_rt", obs_rt, 1);
        drive(0, 0, 3, 3, 1, 0, 3, 0, 0, 0);
        step("w0");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rd0");
        chk("c3.zero_stall", obs_stall, 0);
        chk("c3.zero_sel", obs_rs, 0);
        flush();

        // div then mflo
        drive(0, 0, 3, 3, 0, 0, 0, 1, 1, 1);
        step("div");
        drive(0, 0, 3, 3, 1, 4, 0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step("mflo_d");
            if (obs_stall != 0) n++;
            else break;
        end
        chk("c4.div_len", n, 10);

        // mult, then a stalled mult that must not reload until it issues
        drive(0, 0, 3, 3, 0, 0, 0, 1, 0, 1);
        step("mult");
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step("mult2");
            if (obs_stall != 0) n++;
            else break;
        end
        chk("c4.mult_len", n, 5);
        drive(0, 0, 3, 3, 1, 4, 0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step("mflo_m");
            if (obs_stall != 0) n++;
            else break;
        end
        chk("c4.mult2_len", n, 5);

        // reset during a divide countdown
        drive(0, 0, 3, 3, 1, 1, 2, 1, 1, 1);
        step("div_r");
        drive(1, 0, 1, 3, 1, 4, 0, 0, 0, 1);
        repeat (4) step("mflo_r");
        chk("c5.pre_stall", obs_stall, 1);
        reset = 1'b1;
        step("rst_mid");
        reset = 1'b0;
        step("after_rst");
        chk("c5.stall", obs_stall, 0);
        chk("c5.busy", obs_busy, 0);
        chk("c5.rs", obs_rs, 0);
        chk("c5.rt", obs_rt, 0);

        // random traffic over a small register set
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 60) == 0);
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 1),
                  ($urandom_range(0, 4) == 0) ? 1 : 0);
            step("rand");
        end
        reset = 1'b0;
        nop();
        step("rand_end");
        chk("sb.empty", sb_q.size(), 0);

        // NSTAGE=5: producer tnew=4, consumer Tuse_rt=2
        n5_we = 1; n5_a3 = 7; n5_tnew = 4;
        @(posedge clk);
        #1;
        n5_we = 0; n5_a3 = 0; n5_tnew = 0;
        n5_a2 = 7; n5_tuse_rt = 2;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (n5_stall) begin
                n++;
                @(posedge clk);
                #1;
            end else begin
                break;
            end
        end
        chk("c6.stall_len", n, 2);
        chk("c6.sel_s3", int'(n5_rt_sel), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("c6.stall_s4", int'(n5_stall), 0);
        chk("c6.sel_s4", int'(n5_rt_sel), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("c6.sel_s5", int'(n5_rt_sel), 5);
        chk("c6.busy", int'(n5_md_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
